// File: rtl/cpc_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cpc_rom_loader
//  Purpose  : ROM-image download stage between the mist_io ioctl port and the
//             SDRAM write path of the CPC core. Each 16 KB image page is
//             mapped onto a fixed SDRAM page and model bank. Accepted bytes are
//             queued in a small FIFO so SDRAM writes drain at the memory's own
//             pace. The block also generates the core reset hold, per-page load
//             flags and a sticky overflow flag.
//
//  Ports    : clk_sys         system clock, all logic on posedge
//             reset           synchronous active-high reset
//             ioctl_download  download in progress (mist_io)
//             ioctl_index     download index, 0 = ROM image
//             ioctl_wr        one-cycle byte strobe
//             ioctl_addr      byte offset in the image
//             ioctl_dout      byte data
//             ioctl_wait      backpressure to mist_io (FIFO full)
//             mem_we          SDRAM write request, held until mem_ack
//             mem_addr        SDRAM byte address of the FIFO head
//             mem_bank        SDRAM bank (model select) of the FIFO head
//             mem_din         write data of the FIFO head
//             mem_ack         one-cycle pulse, head write accepted
//             boot_hold       holds the core in reset while loading/flushing
//             page_loaded     bit n set once a byte of image page n is queued
//             overflow        sticky, a byte addressed past page 7 was seen
//
//  Revision : 1.0  initial release
// ============================================================================
module cpc_rom_loader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic        boot_hold,
    output logic [7:0]  page_loaded,
    output logic        overflow
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // One FIFO entry holds {bank, sdram address, data}
    localparam int c_ent_w = 2 + 23 + 8;
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_ent_w-1:0] fifo_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_ptr_w:0]   count_q;

    state_t             state_q;
    state_t             state_d;
    logic               boot_hold_q;
    logic [7:0]         page_loaded_q;
    logic [7:0]         page_loaded_d;
    logic               overflow_q;
    logic               overflow_d;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming byte
    // ------------------------------------------------------------------
    logic [10:0]        w_page;
    logic               w_rom_dl;
    logic               w_strobe;
    logic               w_in_range;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_start;
    logic [8:0]         w_base;
    logic [1:0]         w_bank;
    logic [c_ent_w-1:0] w_entry;

    always_comb begin
        w_page     = ioctl_addr[24:14];
        w_rom_dl   = ioctl_download && (ioctl_index == 8'd0);
        w_strobe   = ioctl_wr && w_rom_dl;
        w_in_range = (w_page[10:3] == 8'd0);
        w_full     = (count_q == c_depth);
        w_empty    = (count_q == '0);
        // A strobe while full is lost; mist_io is expected to honour ioctl_wait
        w_push     = w_strobe && w_in_range && !w_full;
        // An ack with nothing presented is ignored
        w_pop      = mem_ack && !w_empty;

        // Pages n and n+4 share an SDRAM page and differ only in bank;
        // page 3/7 is the MF2 ROM slot at the top of the bank.
        case (w_page[1:0])
            2'd0:    w_base = 9'h000;
            2'd1:    w_base = 9'h100;
            2'd2:    w_base = 9'h107;
            default: w_base = 9'h1FF;
        endcase
        w_bank  = {1'b0, w_page[2]};
        w_entry = {w_bank, w_base, ioctl_addr[13:0], ioctl_dout};
    end

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                fifo_q[wr_ptr_q] <= w_entry;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load sequencer and status flags
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = w_rom_dl ? ST_LOAD : ST_IDLE;
            ST_LOAD:          if (!ioctl_download) state_d = ST_FLUSH;
            ST_FLUSH:         if (w_empty) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase

        w_start = (state_d == ST_LOAD) && (state_q != ST_LOAD);

        // Flags clear when a new ROM download starts; a byte arriving on that
        // same cycle belongs to the new download, so its set wins over the clear.
        page_loaded_d = w_start ? 8'd0 : page_loaded_q;
        if (w_push) begin
            page_loaded_d[w_page[2:0]] = 1'b1;
        end

        overflow_d = w_start ? 1'b0 : overflow_q;
        if (w_strobe && !w_in_range) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            boot_hold_q   <= 1'b0;
            page_loaded_q <= 8'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_hold_q   <= (state_d == ST_LOAD) || (state_d == ST_FLUSH);
            page_loaded_q <= page_loaded_d;
            overflow_q    <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all derived directly from registers)
    // ------------------------------------------------------------------
    assign ioctl_wait                   = w_full;
    assign mem_we                       = !w_empty;
    assign {mem_bank, mem_addr, mem_din} = fifo_q[rd_ptr_q];
    assign boot_hold                    = boot_hold_q;
    assign page_loaded                  = page_loaded_q;
    assign overflow                     = overflow_q;

endmodule

`default_nettype wire
